// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the register-file write-back path.
// Holds the zero-register index, the index type and the queue entry layout.
package regfile_pkg;

  localparam int WBQ_DATA_W = 64;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd31;

  typedef struct packed {
    reg_idx_t              rd;
    logic [WBQ_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// wbq_fwd_match: finds the youngest pending entry for one read index.
// Ports: i_idx read index, i_ent age-ordered entries (0 = oldest),
// i_live occupancy mask, o_hit match flag, o_data matched value.
module wbq_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WBQ_DATA_W
) (
  input  reg_idx_t          i_idx,
  input  wb_entry_t         i_ent [DEPTH],
  input  logic [DEPTH-1:0]  i_live,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_live[k] && i_ent[k].rd == i_idx &&
          i_idx != REG_ZERO) begin
        o_hit  = 1'b1;
        o_data = DATA_W'(i_ent[k].data);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of completed results draining into the regfile
// write port; X31 writes dropped. Ports: clk, reset (async, active-low),
// in_valid/in_ready/in_reg/in_data push side, drain_en, RegWrite/
// WriteRegister/WriteData regfile side, ReadRegister1/2 with
// fwd_hit1/2 and fwd_data1/2 forwarding, count occupancy.
// Forwarding logic is built only when WBQ_FORWARD_EN is defined.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WBQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [4:0]               WriteRegister,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [4:0]               ReadRegister1,
  input  logic [4:0]               ReadRegister2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t      r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;

  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count != CW'(DEPTH));
  assign RegWrite = drain_en && !w_empty;
  assign count    = r_count;

  // X31 still handshakes but is never stored.
  assign w_push = in_valid && in_ready &&
                  (in_reg != REG_ZERO);
  assign w_pop  = RegWrite;

  assign WriteRegister = w_empty ? '0 :
                         r_mem[r_head].rd;
  assign WriteData     = w_empty ? '0 :
                         DATA_W'(r_mem[r_head].data);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail].rd   <= in_reg;
      r_mem[r_tail].data <= WBQ_DATA_W'(in_data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WBQ_FORWARD_EN
  wb_entry_t        w_age [DEPTH];
  logic [DEPTH-1:0] w_live;

  // Rotate storage so index 0 is the head (oldest).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_age[k]  = r_mem[r_head + PW'(k)];
      w_live[k] = (CW'(k) < r_count);
    end
  end

  wbq_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fwd1 (
    .i_idx  (ReadRegister1),
    .i_ent  (w_age),
    .i_live (w_live),
    .o_hit  (fwd_hit1),
    .o_data (fwd_data1)
  );

  wbq_fwd_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fwd2 (
    .i_idx  (ReadRegister2),
    .i_ent  (w_age),
    .i_live (w_live),
    .o_hit  (fwd_hit2),
    .o_data (fwd_data2)
  );
`else
  logic w_unused_rd;

  assign w_unused_rd = ^{ReadRegister1, ReadRegister2};
  assign fwd_hit1    = 1'b0;
  assign fwd_hit2    = 1'b0;
  assign fwd_data1   = '0;
  assign fwd_data2   = '0;
`endif

endmodule
